// File: rtl/seq_divider_16bit_pkg.sv
// rtl/seq_divider_16bit_pkg.sv - shared constants for the sequential divider
// Package div_pkg: FSM state encoding, default operand width, iteration
// counter width and the quotient value reported on a zero divisor.
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/seq_divider_16bit_if.sv
// rtl/seq_divider_16bit_if.sv - request/result bundle for the sequential divider
// Signals: start, a, b (controller -> divider); busy, done, quotient,
// remainder, div_by_zero (divider -> controller).
// master: the controller side.  slave: the divider side.
interface seq_divider_16bit_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_16bit_step.sv
// rtl/seq_divider_16bit_step.sv - one restoring-division step (combinational)
// Ports:
//   rem      in   current partial remainder
//   q_msb    in   next dividend bit to shift into the remainder
//   divisor  in   divisor magnitude
//   rem_next out  partial remainder after the trial subtract / restore
//   q_bit    out  quotient bit produced by this step
module div_step_unit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // rem < divisor can exceed 2^(WIDTH-1), so the shifted value needs WIDTH+1
  // bits and the trial subtract one more bit to expose the borrow.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  assign shifted  = {rem, q_msb};
  assign trial    = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit    = ~trial[WIDTH+1];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider_16bit.sv
// rtl/seq_divider_16bit.sv - sequential restoring divider, quotient and remainder of a/b
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of seq_divider_16bit_if (start/a/b in;
//          busy/done/quotient/remainder/div_by_zero out)
// Optional feature macro: SIGNED_DIV_EN (two's complement operands,
// truncating division). Undefined: unsigned only.
module seq_divider_16bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  seq_divider_16bit_if.slave        bus
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] qreg;     // dividend bits shift out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;

  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic             accept;

  div_step_unit #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .q_msb    (qreg[WIDTH-1]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign q_next = {qreg[WIDTH-2:0], q_bit};
  assign accept = bus.start && (state != S_CALC);

`ifdef SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;

  assign mag_a   = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign mag_b   = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign q_final = neg_q ? -q_next : q_next;
  assign r_final = neg_r ? -rem_next : rem_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept && bus.b != '0) begin
      neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      neg_r <= bus.a[WIDTH-1];
    end
  end
`else
  assign mag_a   = bus.a;
  assign mag_b   = bus.b;
  assign q_final = q_next;
  assign r_final = rem_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rem         <= '0;
      qreg        <= '0;
      divisor     <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        S_CALC: begin
          rem  <= rem_next;
          qreg <= q_next;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state       <= S_DONE;
            quotient_r  <= q_final;
            remainder_r <= r_final;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request
          if (accept) begin
            if (bus.b == '0) begin
              state       <= S_DONE;
              quotient_r  <= DIV_BY_ZERO_Q;
              remainder_r <= bus.a;
              dbz_r       <= 1'b1;
            end else begin
              state   <= S_CALC;
              rem     <= '0;
              qreg    <= mag_a;
              divisor <= mag_b;
              cnt     <= '0;
              dbz_r   <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy        = (state == S_CALC);
  assign bus.done        = (state == S_DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider_16bit.sv
// tb/tb_seq_divider_16bit.sv - self-checking bench for seq_divider_16bit
module tb_seq_divider_16bit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  seq_divider_16bit_if #(.WIDTH(16)) bus ();

  seq_divider_16bit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic division.
  task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dbz, output int lat);
    int sa, sb, iq, ir;
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; dbz = 1'b1; lat = 1;
    end else begin
`ifdef SIGNED_DIV_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'({16'd0, a});
      sb = int'({16'd0, b});
`endif
      iq = sa / sb;
      ir = sa % sb;
      q = iq[15:0]; r = ir[15:0]; dbz = 1'b0; lat = 17;
    end
  endtask

  // Pulse start for one cycle, then count cycles until done (bounded).
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dbz, output int lat, output int busy_n);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b;
    lat = 0; busy_n = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
      if (bus.busy) busy_n++;
    end while (!bus.done && lat < 40);
    q = bus.quotient; r = bus.remainder; dbz = bus.div_by_zero;
  endtask

  task automatic run_and_compare(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] q, r, eq, er;
    logic        dbz, edbz;
    int          lat, elat, busy_n;
    ref_div(a, b, eq, er, edbz, elat);
    run_div(a, b, q, r, dbz, lat, busy_n);
    check({tag, " lat"}, lat, elat);
    check({tag, " q"}, q, eq);
    check({tag, " r"}, r, er);
    check({tag, " dbz"}, dbz, edbz);
  endtask

  initial begin
    logic [15:0] q, r, ra, rb;
    logic        dbz;
    int          lat, busy_n, done_seen;

    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst q", bus.quotient, 0);
    check("rst r", bus.remainder, 0);
    check("rst dbz", bus.div_by_zero, 0);
    rst_n = 1'b1;

    // 100 / 7
    run_div(16'd100, 16'd7, q, r, dbz, lat, busy_n);
    check("t1 busy cycles", busy_n, 16);
    check("t1 lat", lat, 17);
    check("t1 q", q, 14);
    check("t1 r", r, 2);
    check("t1 dbz", dbz, 0);
    repeat (3) @(negedge clk);
    check("t1 done pulse", bus.done, 0);
    check("t1 q held", bus.quotient, 14);
    check("t1 r held", bus.remainder, 2);

    // Boundaries
    run_and_compare("t2 ffff/1", 16'hFFFF, 16'd1);
    run_and_compare("t2 3/ffff", 16'd3, 16'hFFFF);
    run_and_compare("t2 0/9", 16'd0, 16'd9);
    run_and_compare("t2 fffe/ffff", 16'hFFFE, 16'hFFFF);

    // Divide by zero, then the next accepted start clears the flag
    run_div(16'd5, 16'd0, q, r, dbz, lat, busy_n);
    check("t3 lat", lat, 1);
    check("t3 dbz", dbz, 1);
    check("t3 q", q, 16'hFFFF);
    check("t3 r", r, 5);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'd10; bus.b = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("t3 dbz cleared", bus.div_by_zero, 0);
    check("t3 busy", bus.busy, 1);
    repeat (18) @(negedge clk);

    // Start during CALC is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'd50; bus.b = 16'd3;
    lat = 0;
    done_seen = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
      bus.start = (lat == 4);
      if (lat == 4) begin bus.a = 16'd9; bus.b = 16'd2; end
    end
    bus.start = 1'b0;
    check("t4 lat", lat, 17);
    check("t4 q", bus.quotient, 16);
    check("t4 r", bus.remainder, 2);

    // Reset in the middle of CALC
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'd1000; bus.b = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("t5 busy before rst", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5 rst busy", bus.busy, 0);
    check("t5 rst done", bus.done, 0);
    check("t5 rst q", bus.quotient, 0);
    check("t5 rst r", bus.remainder, 0);
    check("t5 rst dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("t5 no done", done_seen, 0);
    run_and_compare("t5 after", 16'd1000, 16'd7);

`ifdef SIGNED_DIV_EN
    run_div(16'hFFF9, 16'd2, q, r, dbz, lat, busy_n);
    check("t6 -7/2 q", q, 16'hFFFD);
    check("t6 -7/2 r", r, 16'hFFFF);
    run_div(16'h8000, 16'hFFFF, q, r, dbz, lat, busy_n);
    check("t6 min/-1 q", q, 16'h8000);
    check("t6 min/-1 r", r, 0);
    run_and_compare("t6 7/-2", 16'd7, 16'hFFFE);
    run_and_compare("t6 -9/0", 16'hFFF7, 16'd0);
`endif

    // Randomized against the reference
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = 16'($urandom_range(16'h8000, 16'hFFFF));
        default: rb = 16'($urandom);
      endcase
      run_and_compare("rand", ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
